// File: rtl/wbuf_loader.sv
// Purpose : converts a MEM_DATA_WIDTH word stream into weight-buffer writes, filling
//           every bank of a row before advancing the row address; a command (base row,
//           row count) starts a transfer, with busy status and a one-cycle done pulse.
// Latency : write strobe/addr/data registered, 1 cycle after the stream handshake.
// Backpres: s_data_ready is high for the whole LOAD state and never depends on s_data_valid;
//           bubbles on s_data_valid simply produce write-idle cycles.
// Ports   : clk/reset (async, active-high); cfg_start/cfg_base_addr/cfg_num_rows command;
//           s_data_valid/s_data_ready/s_data stream in; mem_write_req/addr/data buffer
//           write out; busy (not IDLE), done (one-cycle completion pulse).
module wbuf_loader #(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ARRAY_N        = 4,
  parameter int ARRAY_M        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int BUF_ADDR_WIDTH = 9,
  parameter int GROUP_SIZE     = (DATA_WIDTH * ARRAY_M) / MEM_DATA_WIDTH,
  parameter int NUM_BUFS       = ARRAY_N * GROUP_SIZE,
  parameter int BUF_ID_W       = $clog2(NUM_BUFS),
  parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [BUF_ADDR_WIDTH:0]   cfg_num_rows,
  input  logic                      s_data_valid,
  output logic                      s_data_ready,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      busy,
  output logic                      done
);

  // Bank counter keeps at least one bit so it exists when there is a single bank.
  localparam int ID_W = (BUF_ID_W > 0) ? BUF_ID_W : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state, state_nxt;
  logic [BUF_ADDR_WIDTH-1:0] row_addr;
  logic [BUF_ADDR_WIDTH:0]   rows_left;
  logic [ID_W-1:0]           buf_id;
  logic                      hs;
  logic                      last_buf;
  logic                      last_word;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr;

  assign hs        = s_data_valid && s_data_ready;
  assign last_buf  = (buf_id == ID_W'(NUM_BUFS - 1));
  assign last_word = last_buf && (rows_left == (BUF_ADDR_WIDTH + 1)'(1));

  // With a single bank per row the bank field vanishes from the address.
  generate
    if (BUF_ID_W == 0) begin : g_no_id
      assign cur_addr = MEM_ADDR_WIDTH'(row_addr);
    end else begin : g_id
      assign cur_addr = {row_addr, buf_id[BUF_ID_W-1:0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    s_data_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          state_nxt = (cfg_num_rows == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        s_data_ready = 1'b1;
        if (hs && last_word) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row/bank counters; rows_left counts completed rows down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_addr  <= '0;
      rows_left <= '0;
      buf_id    <= '0;
    end else begin
      if (state == IDLE && cfg_start) begin
        row_addr  <= cfg_base_addr;
        rows_left <= cfg_num_rows;
        buf_id    <= '0;
      end else if (hs) begin
        if (last_buf) begin
          buf_id    <= '0;
          row_addr  <= row_addr + BUF_ADDR_WIDTH'(1);  // wraps modulo buffer depth
          rows_left <= rows_left - (BUF_ADDR_WIDTH + 1)'(1);
        end else begin
          buf_id <= buf_id + ID_W'(1);
        end
      end
    end
  end

  // Write port: strobe follows the handshake, addr/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write_req <= hs;
      if (hs) begin
        mem_write_addr <= cur_addr;
        mem_write_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_wbuf_loader.sv
module tb_wbuf_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_start = 1'b0;
  logic [8:0]  cfg_base_addr = '0;
  logic [9:0]  cfg_num_rows = '0;
  logic        s_data_valid = 1'b0;
  logic        s_data_ready;
  logic [63:0] s_data = '0;
  logic        mem_write_req;
  logic [10:0] mem_write_addr;
  logic [63:0] mem_write_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  wbuf_loader dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_rows   (cfg_num_rows),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .s_data         (s_data),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One command: valid pattern repeats with period per (bit i = valid in cycle i).
  typedef struct {
    string      name;
    logic [8:0] base;
    logic [9:0] rows;
    logic [7:0] pat;
    int         per;
    int         mid_start;   // cycle to pulse a stray cfg_start, -1 for none
    int         exp_n;
    logic [10:0] exp_addr0;
    int         exp_done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic run_case(input vec_t v);
    int nw, sent, done_cyc;
    bit got_done;
    logic [10:0] ea;
    @(negedge clk);
    cfg_base_addr = v.base;
    cfg_num_rows  = v.rows;
    cfg_start     = 1'b1;
    s_data_valid  = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    nw = 0; sent = 0; got_done = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      if (mem_write_req) begin
        ea = v.exp_addr0 + 11'(nw);
        chk({v.name, "_addr"}, 64'(mem_write_addr), 64'(ea));
        chk({v.name, "_data"}, mem_write_data, 64'(nw));
        nw++;
      end
      if (v.rows == 0) chk({v.name, "_ready_low"}, 64'(s_data_ready), 64'd0);
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        chk({v.name, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
        chk({v.name, "_done_with_last_write"}, 64'(mem_write_req), 64'(v.exp_n != 0));
        chk({v.name, "_write_count"}, 64'(nw), 64'(v.exp_n));
      end
      if (cyc == v.mid_start) begin
        cfg_start     = 1'b1;
        cfg_base_addr = 9'h040;
        cfg_num_rows  = 10'd1;
      end else begin
        cfg_start = 1'b0;
      end
      s_data_valid = v.pat[cyc % v.per];
      s_data       = 64'(sent);
      if (s_data_valid && s_data_ready) sent++;
      @(negedge clk);
    end
    cfg_start    = 1'b0;
    s_data_valid = 1'b0;
    if (!got_done) begin
      chk({v.name, "_done_timeout"}, 64'(got_done), 64'd1);
    end else begin
      chk({v.name, "_busy_after_done"}, 64'(busy), 64'd0);
      chk({v.name, "_no_write_after_done"}, 64'(mem_write_req), 64'd0);
      chk({v.name, "_done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int nw;
    vecs[0] = '{"basic",    9'd5,     10'd2, 8'hFF,       1, -1,  8, 11'h014,  8};
    vecs[1] = '{"bkpress",  9'd5,     10'd2, 8'b0000_0001, 3, -1,  8, 11'h014, 22};
    vecs[2] = '{"wrap",     9'd511,   10'd2, 8'hFF,       1, -1,  8, 11'h7FC,  8};
    vecs[3] = '{"zero",     9'd7,     10'd0, 8'hFF,       1, -1,  0, 11'h000,  0};
    vecs[4] = '{"ign_start",9'd0,     10'd3, 8'hFF,       1,  4, 12, 11'h000, 12};
    vecs[5] = '{"alt",      9'h100,   10'd1, 8'b0000_0001, 2, -1,  4, 11'h400,  7};

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_req",   64'(mem_write_req),  64'd0);
    chk("rst_addr",  64'(mem_write_addr), 64'd0);
    chk("rst_data",  mem_write_data,      64'd0);
    chk("rst_ready", 64'(s_data_ready),   64'd0);
    chk("rst_busy",  64'(busy),           64'd0);
    chk("rst_done",  64'(done),           64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_write_req || busy) nw++;
    end
    chk("idle_no_activity", 64'(nw), 64'd0);

    foreach (vecs[i]) run_case(vecs[i]);

    // cfg_start during the done cycle is ignored, accepted one cycle later.
    @(negedge clk);
    cfg_base_addr = 9'd3;
    cfg_num_rows  = 10'd0;
    cfg_start     = 1'b1;
    @(negedge clk);
    chk("dstart_done1", 64'(done), 64'd1);
    @(negedge clk);
    chk("dstart_ignored_busy", 64'(busy), 64'd0);
    chk("dstart_ignored_done", 64'(done), 64'd0);
    @(negedge clk);
    cfg_start = 1'b0;
    chk("dstart_accepted", 64'(done), 64'd1);
    @(negedge clk);
    chk("dstart_idle", 64'(busy), 64'd0);

    // Reset after six writes of a four-row load.
    @(negedge clk);
    cfg_base_addr = 9'd0;
    cfg_num_rows  = 10'd4;
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    nw = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mem_write_req) nw++;
      if (nw == 6) break;
      s_data_valid = 1'b1;
      s_data       = 64'(cyc);
      @(negedge clk);
    end
    chk("midrst_writes_before", 64'(nw), 64'd6);
    reset = 1'b1;
    #1;
    chk("midrst_req_dropped", 64'(mem_write_req), 64'd0);
    chk("midrst_busy",        64'(busy),          64'd0);
    chk("midrst_ready",       64'(s_data_ready),  64'd0);
    @(negedge clk);
    reset        = 1'b0;
    s_data_valid = 1'b0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      s_data_valid = 1'b1;
      if (mem_write_req || done) nw++;
      @(negedge clk);
    end
    s_data_valid = 1'b0;
    chk("midrst_no_resume", 64'(nw), 64'd0);
    run_case('{"after_rst", 9'd0, 10'd1, 8'hFF, 1, -1, 4, 11'h000, 4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
